spi_memory_controller: RTL and testbench
========================================

# spi_memory_controller

Sequencing FSM for the SPI memory slave. It watches the conditioned chip-select and the SCLK rising-edge strobe, and counts bits. It drives the control strobes for the `shiftregister` datapath (parallel load), the address latch, the data-memory write enable and the MISO tri-state buffer. One transaction is an address/command byte, then one data byte: written into memory, or read out of memory and shifted out.

## Interface
Parameters:
- `WIDTH`, 8: shift-register/frame width in bits; frame = (WIDTH-1) address bits + 1 R/W bit.
- `CNTW`, 4: bit-counter width; must satisfy 2^CNTW > WIDTH.

Ports:
- `clk`  input  1  system clock; all state changes on rising edge.
- `resetN`  input  1  asynchronous, active-low reset.
- `csN`  input  1  chip select, active-low, already synchronized to `clk`.
- `sclkPosEdge`  input  1  one-`clk` pulse per SCLK rising edge; the same strobe drives the shift register's `peripheralClkEdge`.
- `srParallelOut`  input  WIDTH  shift-register `parallelDataOut`.
- `srParallelLoad`  output  1  shift-register `parallelLoad` strobe.
- `addrLatchEn`  output  1  address-latch enable; the latch captures `srParallelOut[WIDTH-1:1]`.
- `dmWriteEn`  output  1  data-memory write enable.
- `misoEn`  output  1  MISO buffer enable.
- `rwBit`  output  1  latched R/W bit; 1 = read.
- `busy`  output  1  high in every state except IDLE.
- `state`  output  3  current state encoding, for debug and verification.

## Operation
- States and encodings: IDLE=0, GET_ADDR=1, LATCH_ADDR=2, READ_LOAD=3, READ_SHIFT=4, WRITE_SHIFT=5, WRITE_MEM=6, DONE=7.
- Bit counter `cnt` (CNTW bits):
  - Increments only on `sclkPosEdge` in GET_ADDR, READ_SHIFT and WRITE_SHIFT.
  - Cleared on entry to GET_ADDR, READ_LOAD and WRITE_SHIFT.
  - Never wraps; it cannot exceed WIDTH.
- Transitions:
  - IDLE: `csN`=0 -> GET_ADDR, `cnt`=0.
  - GET_ADDR: `sclkPosEdge` with `cnt`==WIDTH-1 -> LATCH_ADDR; otherwise `cnt`++ on each pulse.
  - LATCH_ADDR: lasts one cycle. Captures `rwBit` <= `srParallelOut[0]`, then goes to READ_LOAD if `srParallelOut[0]`=1, else WRITE_SHIFT.
  - READ_LOAD: lasts one cycle -> READ_SHIFT.
  - READ_SHIFT / WRITE_SHIFT: `sclkPosEdge` with `cnt`==WIDTH-1 -> DONE (read) or WRITE_MEM (write).
  - WRITE_MEM: lasts one cycle -> DONE.
  - DONE: holds until `csN`=1.
- Abort rule: `csN`=1 sampled in any state -> IDLE next edge, with `cnt`=0. Abort has priority over every other transition, including a simultaneous final `sclkPosEdge`. No further strobe is issued after an abort.
- Outputs are Moore (decoded from registered state, glitch-free):
  - `addrLatchEn`=1 only in LATCH_ADDR.
  - `srParallelLoad`=1 only in READ_LOAD.
  - `dmWriteEn`=1 only in WRITE_MEM.
  - `misoEn`=1 in READ_LOAD and READ_SHIFT.
- `rwBit` holds its value until the next LATCH_ADDR or reset; it is not cleared by an abort.
- `sclkPosEdge` is ignored in IDLE, LATCH_ADDR, READ_LOAD, WRITE_MEM and DONE. The SPI master guarantees at least 3 `clk` cycles between SCLK edges.

## Timing
- Reset (`resetN`=0, any time, asynchronous): `state`=IDLE, `cnt`=0, `rwBit`=0, and all strobes, `misoEn` and `busy` = 0. This holds within the same cycle, including mid-transaction. Release is synchronous to the next `clk` edge.
- Edge numbering in the following items is counted from the first `clk` edge that samples `csN`=0.
- `busy` rises 1 cycle after `csN` is first sampled low.
- Address phase:
  - The WIDTH-th `sclkPosEdge` is accepted at edge E. LATCH_ADDR is active in cycle E..E+1.
  - `srParallelOut` already holds the bit shifted at edge E, so the address and R/W bit are valid when the latch samples at edge E+1.
- Read phase:
  - READ_LOAD is active in cycle E+1..E+2, so the shift register loads memory data at edge E+2.
  - The memory read address was latched at edge E+1, so the memory output is valid one cycle before the load.
- Write phase:
  - The WIDTH-th data pulse is accepted at edge F; `dmWriteEn` is high during F..F+1.
  - Memory writes the full byte at edge F+1.
- Each strobe (`addrLatchEn`, `srParallelLoad`, `dmWriteEn`) is exactly 1 `clk` cycle wide, once per transaction.

## Test plan
- Reset mid-read: assert `resetN`=0 asynchronously during READ_SHIFT with `cnt`=3 -> same cycle `state`=0, `misoEn`=0, `busy`=0. After release, stays in IDLE while `csN`=1.
- Write transaction: `csN`=0, shift 0x54 (addr 0x2A, R/W=0) then 0xC3 -> `addrLatchEn` is one pulse with `srParallelOut`=0x54. `dmWriteEn` is one pulse with `srParallelOut`=0xC3. `misoEn` never asserts. Ends in `state`=7.
- Read transaction: shift 0x55 (addr 0x2A, R/W=1) -> `rwBit`=1. `srParallelLoad` pulses exactly 1 cycle after `addrLatchEn`. `misoEn`=1 from READ_LOAD for 8 further pulses. Then DONE with `misoEn`=0 and `dmWriteEn` never 1.
- Abort: `csN`=1 on the same cycle as the 8th data `sclkPosEdge` of a write -> next `state`=0, `dmWriteEn` never asserted, `cnt`=0.
- Spurious pulses: `sclkPosEdge` in IDLE (`csN`=1) and in DONE -> no state change and no strobes. A new `csN` falling edge after `csN`=1 starts a clean transaction with `cnt`=0.
- Back-to-back: write 0xA1 to addr 0x10, deassert `csN` for 1 cycle, then read addr 0x10 -> the second transaction's LATCH_ADDR occurs with `rwBit` updated from 0 to 1. Strobe counts are exactly 1 each per transaction.

Source files
------------

// File: rtl/spi_memory_controller.sv
// Sequencing FSM for the SPI memory slave: one address/command frame followed by
// one data frame, steering the shift register, address latch, memory write and MISO buffer.
module spi_memory_controller #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             csN,
  input  logic             sclkPosEdge,
  input  logic [WIDTH-1:0] srParallelOut,
  output logic             srParallelLoad,
  output logic             addrLatchEn,
  output logic             dmWriteEn,
  output logic             misoEn,
  output logic             rwBit,
  output logic             busy,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GET_ADDR    = 3'd1,
    LATCH_ADDR  = 3'd2,
    READ_LOAD   = 3'd3,
    READ_SHIFT  = 3'd4,
    WRITE_SHIFT = 3'd5,
    WRITE_MEM   = 3'd6,
    DONE        = 3'd7
  } state_t;

  localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);

  state_t          state_reg, state_next;
  logic [CNTW-1:0] cnt_reg, cnt_next;
  logic            rw_reg, rw_next;

  // Address bits are consumed by the external latch, only the R/W bit is used here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^srParallelOut[WIDTH-1:1];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rw_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rw_reg    <= rw_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rw_next    = rw_reg;

    // The R/W bit is captured alongside the external address latch strobe.
    if (state_reg == LATCH_ADDR) begin
      rw_next = srParallelOut[0];
    end

    if (csN) begin
      // Deselect aborts from any state, even on a simultaneous final SCLK edge.
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = GET_ADDR;
          cnt_next   = '0;
        end
        GET_ADDR: begin
          if (sclkPosEdge) begin
            cnt_next = cnt_reg + CNTW'(1);
            if (cnt_reg == LAST_BIT) begin
              state_next = LATCH_ADDR;
            end
          end
        end
        LATCH_ADDR: begin
          cnt_next   = '0;
          state_next = srParallelOut[0] ? READ_LOAD : WRITE_SHIFT;
        end
        READ_LOAD: begin
          state_next = READ_SHIFT;
        end
        READ_SHIFT: begin
          if (sclkPosEdge) begin
            cnt_next = cnt_reg + CNTW'(1);
            if (cnt_reg == LAST_BIT) begin
              state_next = DONE;
            end
          end
        end
        WRITE_SHIFT: begin
          if (sclkPosEdge) begin
            cnt_next = cnt_reg + CNTW'(1);
            if (cnt_reg == LAST_BIT) begin
              state_next = WRITE_MEM;
            end
          end
        end
        WRITE_MEM: begin
          state_next = DONE;
        end
        DONE: begin
          state_next = DONE;
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Moore decode straight from the state register keeps every strobe glitch-free.
  always_comb begin
    addrLatchEn    = (state_reg == LATCH_ADDR);
    srParallelLoad = (state_reg == READ_LOAD);
    dmWriteEn      = (state_reg == WRITE_MEM);
    misoEn         = (state_reg == READ_LOAD) || (state_reg == READ_SHIFT);
    busy           = (state_reg != IDLE);
  end

  assign rwBit = rw_reg;
  assign state = state_reg;

endmodule

// File: tb/tb_spi_memory_controller.sv
// Bench: drives SPI frames around a behavioural shift register/latch/memory environment
// and scoreboards the controller's strobes and read-back data against a reference memory.
module tb_spi_memory_controller;
  localparam int W = 8;

  localparam int K_ALE = 1;
  localparam int K_LD  = 2;
  localparam int K_WE  = 3;
  localparam int K_RD  = 4;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic         clk = 1'b0;
  logic         resetN = 1'b0;
  logic         csN = 1'b1;
  logic         sclkPosEdge = 1'b0;
  logic [W-1:0] srParallelOut;
  logic         srParallelLoad, addrLatchEn, dmWriteEn, misoEn, rwBit, busy;
  logic [2:0]   state;

  int errors = 0;
  int checks = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  spi_memory_controller #(.WIDTH(W), .CNTW(4)) dut (
    .clk(clk),
    .resetN(resetN),
    .csN(csN),
    .sclkPosEdge(sclkPosEdge),
    .srParallelOut(srParallelOut),
    .srParallelLoad(srParallelLoad),
    .addrLatchEn(addrLatchEn),
    .dmWriteEn(dmWriteEn),
    .misoEn(misoEn),
    .rwBit(rwBit),
    .busy(busy),
    .state(state)
  );

  // Environment: shift register, address latch and data memory the controller steers.
  logic [W-1:0] sr_q = '0;
  logic         mosi = 1'b0;
  logic [6:0]   addr_q = '0;
  logic [7:0]   env_mem [128];
  logic [7:0]   ref_mem [128];

  always @(posedge clk) begin
    if (srParallelLoad) sr_q <= env_mem[addr_q];
    else if (sclkPosEdge) sr_q <= {sr_q[W-2:0], mosi};
    if (addrLatchEn) addr_q <= sr_q[W-1:1];
    if (dmWriteEn) env_mem[addr_q] <= sr_q;
  end
  assign srParallelOut = sr_q;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Monitor: pops an expected event for every strobe and every completed read byte.
  int       cyc_since_ale = 0;
  logic [7:0] last_frame = '0;
  logic [7:0] rx = '0;
  int       rxn = 0;

  always @(negedge clk) begin
    ev_t e;
    int  kind;
    int  val;
    cyc_since_ale++;
    if (resetN) begin
      chk("busy_vs_state", busy, (state != 3'd0) ? 1 : 0);
      kind = 0;
      val  = 0;
      if (addrLatchEn) begin kind = K_ALE; val = srParallelOut; last_frame = srParallelOut; end
      if (srParallelLoad) begin kind = K_LD; val = cyc_since_ale; end
      if (dmWriteEn) begin kind = K_WE; val = srParallelOut; end
      if (int'(addrLatchEn) + int'(srParallelLoad) + int'(dmWriteEn) > 1) begin
        chk("strobes_exclusive", 0, 1);
      end
      if (kind != 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", kind, 0);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind", kind, e.kind);
          chk("strobe_value", val, e.val);
        end
      end
      if (addrLatchEn) cyc_since_ale = 0;
      if (misoEn) chk("miso_only_in_read", int'(last_frame[0]), 1);
      if (misoEn && sclkPosEdge) begin
        rx = {rx[6:0], srParallelOut[W-1]};
        rxn++;
        if (rxn == 8) begin
          rxn = 0;
          if (exp_q.size() == 0) begin
            chk("unexpected_read", int'(rx), -1);
          end else begin
            e = exp_q.pop_front();
            chk("read_kind", K_RD, e.kind);
            chk("read_data", int'(rx), e.val);
          end
        end
      end else if (!misoEn) begin
        rxn = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic b, input logic rise_cs);
    mosi = b;
    sclkPosEdge = 1'b1;
    if (rise_cs) csN = 1'b1;
    tick();
    sclkPosEdge = 1'b0;
    repeat ($urandom_range(2, 4)) tick();
  endtask

  // abort_at: index of the SCLK pulse (0..15) on which csN rises, or -1 for none.
  task automatic xfer(input logic rd, input logic [6:0] addr, input logic [7:0] data, input int abort_at);
    logic [7:0] frame;
    logic       b;
    frame = {addr, rd};
    if (abort_at < 0 || abort_at >= 8) push(K_ALE, frame);
    if (rd) begin
      if (abort_at < 0 || abort_at >= 8) push(K_LD, 1);
      if (abort_at < 0) push(K_RD, ref_mem[addr]);
    end else if (abort_at < 0) begin
      push(K_WE, data);
      ref_mem[addr] = data;
    end
    csN = 1'b0;
    tick();
    chk("busy_rise", busy, 1);
    chk("get_addr_state", state, 1);
    for (int i = 0; i < 16; i++) begin
      b = (i < 8) ? frame[7 - i] : data[15 - i];
      pulse(b, i == abort_at);
      if (i == abort_at) break;
    end
    if (abort_at >= 0) begin
      chk("abort_state", state, 0);
      chk("abort_busy", busy, 0);
    end else begin
      chk("done_state", state, 7);
      chk("done_miso", misoEn, 0);
      chk("rwBit", rwBit, rd);
    end
  endtask

  task automatic end_tx();
    csN = 1'b1;
    tick();
    chk("idle_after_cs", state, 0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      env_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    #1;
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rwBit", rwBit, 0);
    chk("rst_strobes", {addrLatchEn, srParallelLoad, dmWriteEn, misoEn}, 0);
    tick();
    tick();
    resetN = 1'b1;
    tick();

    // Spurious pulse while deselected.
    pulse(1'b1, 1'b0);
    chk("idle_spurious", state, 0);

    // Write 0xC3 to 0x2A, spurious pulse in DONE, then read it back.
    xfer(1'b0, 7'h2A, 8'hC3, -1);
    pulse(1'b1, 1'b0);
    chk("done_spurious", state, 7);
    end_tx();
    xfer(1'b1, 7'h2A, 8'h00, -1);
    end_tx();

    // Abort on the final data pulse of a write: memory must keep 0xC3.
    xfer(1'b0, 7'h2A, 8'h11, 15);
    xfer(1'b1, 7'h2A, 8'h00, -1);
    end_tx();

    // Back-to-back write then read with a single deselected cycle.
    xfer(1'b0, 7'h10, 8'hA1, -1);
    csN = 1'b1;
    tick();
    xfer(1'b1, 7'h10, 8'h00, -1);
    end_tx();

    // Asynchronous reset mid-read after 3 data pulses.
    push(K_ALE, {7'h10, 1'b1});
    push(K_LD, 1);
    csN = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) pulse((i == 7) ? 1'b1 : ((7'h10 >> (6 - i)) & 1'b1), 1'b0);
    for (int i = 0; i < 3; i++) pulse(1'b0, 1'b0);
    #2;
    resetN = 1'b0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_miso", misoEn, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_rwBit", rwBit, 0);
    csN = 1'b1;
    tick();
    tick();
    resetN = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", state, 0);

    // Randomized traffic over a small address window so reads hit written data.
    for (int n = 0; n < 40; n++) begin
      xfer(1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 8'($urandom), -1);
      end_tx();
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
